// File: rtl/t2mi_ts_encapsulator.sv
// T2-MI to MPEG-TS encapsulator: buffers the packetiser byte stream and emits 188-byte TS
// packets on one PID with PUSI/pointer_field/CC, optionally padding with null packets.
module t2mi_ts_encapsulator #(
    parameter int FIFO_AW     = 11,
    parameter int SQ_AW       = 4,
    parameter bit NULL_INSERT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  IN_DATA,
    input  logic [7:0]  IN_POINTER,
    input  logic        IN_ENA,
    input  logic [12:0] PID,
    input  logic        OUT_RDY,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_ENA,
    output logic        OUT_SYNC,
    output logic        OVERFLOW,
    output logic [2:0]  state_mon
);

    localparam int DEPTH    = 1 << FIFO_AW;
    localparam int SQ_DEPTH = 1 << SQ_AW;

    typedef enum logic [2:0] {IDLE, HDR, PTR, PAY, NHDR, NPAY} state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] sq_mem [SQ_DEPTH];
    logic [FIFO_AW-1:0] wr_idx, rd_idx, sq_head, diff;
    logic [FIFO_AW:0]   level;
    logic [SQ_AW-1:0]   sq_wr, sq_rd;
    logic [SQ_AW:0]     sq_cnt;
    logic               start_pending;
    logic               rd_en, wr_en, fifo_full, sq_full, sq_empty, sq_pop, sq_push;

    state_t             state;
    logic               pusi;
    logic [7:0]         ptr;
    logic [12:0]        pid_q;
    logic [3:0]         cc;
    logic [7:0]         cnt;

    // A full FIFO still accepts a write when a payload byte leaves in the same cycle.
    assign rd_en     = (state == PAY) && OUT_RDY;
    assign fifo_full = level[FIFO_AW];
    assign wr_en     = IN_ENA && (!fifo_full || rd_en);
    assign sq_empty  = (sq_cnt == '0);
    assign sq_full   = sq_cnt[SQ_AW];
    assign sq_head   = sq_mem[sq_rd];
    assign sq_pop    = rd_en && !sq_empty && (sq_head == rd_idx);
    assign sq_push   = wr_en && start_pending && (!sq_full || sq_pop);
    assign diff      = sq_head - rd_idx;
    assign state_mon = state;

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_idx] <= IN_DATA;
        if (sq_push)
            sq_mem[sq_wr] <= wr_idx;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            level         <= '0;
            sq_wr         <= '0;
            sq_rd         <= '0;
            sq_cnt        <= '0;
            start_pending <= 1'b1;
            OVERFLOW      <= 1'b0;
        end else begin
            if (wr_en)
                wr_idx <= wr_idx + FIFO_AW'(1);
            if (rd_en)
                rd_idx <= rd_idx + FIFO_AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + (FIFO_AW+1)'(1);
                2'b01:   level <= level - (FIFO_AW+1)'(1);
                default: level <= level;
            endcase
            if (sq_push)
                sq_wr <= sq_wr + SQ_AW'(1);
            if (sq_pop)
                sq_rd <= sq_rd + SQ_AW'(1);
            case ({sq_push, sq_pop})
                2'b10:   sq_cnt <= sq_cnt + (SQ_AW+1)'(1);
                2'b01:   sq_cnt <= sq_cnt - (SQ_AW+1)'(1);
                default: sq_cnt <= sq_cnt;
            endcase
            // Start tracking follows every offered byte, even one dropped on overflow.
            if (IN_ENA)
                start_pending <= (IN_POINTER == 8'd1);
            if ((IN_ENA && !wr_en) || (wr_en && start_pending && sq_full && !sq_pop))
                OVERFLOW <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            OUT_DATA <= 8'h00;
            OUT_ENA  <= 1'b0;
            OUT_SYNC <= 1'b0;
            pusi     <= 1'b0;
            ptr      <= 8'h00;
            pid_q    <= '0;
            cc       <= 4'h0;
            cnt      <= 8'h00;
        end else begin
            OUT_ENA  <= 1'b0;
            OUT_SYNC <= 1'b0;
            if (OUT_RDY) begin
                case (state)
                    IDLE: begin
                        cnt <= 8'h00;
                        if (level >= (FIFO_AW+1)'(184)) begin
                            pid_q <= PID;
                            if (!sq_empty && (diff < FIFO_AW'(183))) begin
                                pusi <= 1'b1;
                                ptr  <= diff[7:0];
                            end else begin
                                pusi <= 1'b0;
                                ptr  <= 8'h00;
                            end
                            state <= HDR;
                        end else if (NULL_INSERT) begin
                            state <= NHDR;
                        end
                    end
                    HDR: begin
                        OUT_ENA <= 1'b1;
                        cnt     <= cnt + 8'd1;
                        case (cnt[1:0])
                            2'd0: begin
                                OUT_DATA <= 8'h47;
                                OUT_SYNC <= 1'b1;
                            end
                            2'd1:    OUT_DATA <= {1'b0, pusi, 1'b0, pid_q[12:8]};
                            2'd2:    OUT_DATA <= pid_q[7:0];
                            default: OUT_DATA <= {4'b0001, cc};
                        endcase
                        if (cnt == 8'd3) begin
                            if (pusi) begin
                                state <= PTR;
                            end else begin
                                state <= PAY;
                                cnt   <= 8'd184;
                            end
                        end
                    end
                    PTR: begin
                        OUT_ENA  <= 1'b1;
                        OUT_DATA <= ptr;
                        cnt      <= 8'd183;
                        state    <= PAY;
                    end
                    PAY: begin
                        OUT_ENA  <= 1'b1;
                        OUT_DATA <= mem[rd_idx];
                        cnt      <= cnt - 8'd1;
                        if (cnt == 8'd1) begin
                            cc    <= cc + 4'd1;
                            state <= IDLE;
                        end
                    end
                    NHDR: begin
                        OUT_ENA <= 1'b1;
                        cnt     <= cnt + 8'd1;
                        case (cnt[1:0])
                            2'd0: begin
                                OUT_DATA <= 8'h47;
                                OUT_SYNC <= 1'b1;
                            end
                            2'd1:    OUT_DATA <= 8'h1F;
                            2'd2:    OUT_DATA <= 8'hFF;
                            default: OUT_DATA <= 8'h10;
                        endcase
                        if (cnt == 8'd3) begin
                            state <= NPAY;
                            cnt   <= 8'd184;
                        end
                    end
                    NPAY: begin
                        OUT_ENA  <= 1'b1;
                        OUT_DATA <= 8'hFF;
                        cnt      <= cnt - 8'd1;
                        if (cnt == 8'd1)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
